// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the fifo enqueue arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 16;

    // Width of a producer index (grant_id, rr_ptr).
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the beat counter: must be able to hold MAX_BURST.
    function automatic int cnt_w(input int m);
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/fifo_enq_arbiter_rr_picker.sv
// Cyclic first-set finder: first request at or after the start index, wrapping.
// Latency: purely combinational.
// Backpressure: none, no state.
module rr_picker #(
    parameter int N  = 4,
    parameter int GW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [GW-1:0] i_start,
    output logic          o_found,
    output logic [GW-1:0] o_idx
);

    int w_j;

    // Scan offsets from far to near so the nearest hit to i_start wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = (int'(i_start) + k) % N;
            if (i_req[w_j]) begin
                o_found = 1'b1;
                o_idx   = GW'(w_j);
            end
        end
    end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// Burst-locked round-robin arbiter sharing one fifo enqueue port among NUM_REQ producers.
// Latency: 1 cycle IDLE->grant; back-to-back bursts hand over with no bubble.
// Backpressure: enq_ready passes straight to the owner's req_ready; low stalls the burst.
module fifo_enq_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          enq_valid,
    output logic [DATA_WIDTH-1:0]         enq_data,
    input  logic                          enq_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int GW = grant_w(NUM_REQ);
    localparam int CW = cnt_w(MAX_BURST);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [GW-1:0]      r_grant;
    logic [GW-1:0]      r_rr_ptr;
    logic [CW-1:0]      r_beat_cnt;

    logic               w_locked;
    logic               w_xfer;
    logic               w_release;
    logic [GW-1:0]      w_ptr_nxt;
    logic [NUM_REQ-1:0] w_pick_req;
    logic [GW-1:0]      w_pick_start;
    logic               w_pick_found;
    logic [GW-1:0]      w_pick_idx;

    assign w_locked  = (r_state == LOCKED);
    assign w_ptr_nxt = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
    assign grant_id  = r_grant;
    assign busy      = w_locked;

    // Datapath mux: only the owner sees enq_ready, and only while LOCKED.
    always_comb begin
        enq_valid = 1'b0;
        enq_data  = '0;
        req_ready = '0;
        if (w_locked) begin
            enq_valid          = req_valid[r_grant];
            enq_data           = req_data[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
            req_ready[r_grant] = enq_ready;
        end
    end

    assign w_xfer    = enq_valid && enq_ready;
    assign w_release = w_xfer && (req_last[r_grant] || (r_beat_cnt == CW'(MAX_BURST - 1)));

    // One picker serves both arbitration points: IDLE scans from rr_ptr, a release
    // scans from the owner's successor with the owner masked out.
    always_comb begin
        w_pick_req   = req_valid;
        w_pick_start = r_rr_ptr;
        if (w_locked) begin
            w_pick_req[r_grant] = 1'b0;
            w_pick_start        = w_ptr_nxt;
        end
    end

    rr_picker #(
        .N  (NUM_REQ),
        .GW (GW)
    ) u_picker (
        .i_req   (w_pick_req),
        .i_start (w_pick_start),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    // Next-state: lock on any request, fall back to IDLE only when a release finds nobody.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pick_found) w_state_nxt = LOCKED;
            LOCKED:  if (w_release && !w_pick_found) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Grant, round-robin pointer and beat counter; the pointer moves only on release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else if (!w_locked) begin
            if (w_pick_found) r_grant <= w_pick_idx;
        end else if (w_release) begin
            r_rr_ptr   <= w_ptr_nxt;
            r_beat_cnt <= '0;
            if (w_pick_found) r_grant <= w_pick_idx;
        end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Self-checking bench for fifo_enq_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
// Latency: n/a.
// Backpressure: enq_ready driven directly by the bench.
module tb_fifo_enq_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic              clk;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              enq_valid;
    logic [DW-1:0]     enq_data;
    logic              enq_ready;
    logic [1:0]        grant_id;
    logic              busy;

    fifo_enq_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic [1:0] g, input logic b,
                              input logic ev, input logic [7:0] ed, input logic [3:0] rr);
        chk({tag, ".grant_id"},  32'(grant_id),  32'(g));
        chk({tag, ".busy"},      32'(busy),      32'(b));
        chk({tag, ".enq_valid"}, 32'(enq_valid), 32'(ev));
        chk({tag, ".enq_data"},  32'(enq_data),  32'(ed));
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(rr));
    endtask

    // Drive one cycle of inputs just after a rising edge, then move to the falling edge.
    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                        input logic r);
        @(posedge clk);
        #1;
        req_valid = v;
        req_data  = d;
        req_last  = l;
        enq_ready = r;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        r;
        logic [1:0]  g;
        logic        b;
        logic        ev;
        logic [7:0]  ed;
        logic [3:0]  rr;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                                input logic [1:0] g, input logic b, input logic ev,
                                input logic [7:0] ed, input logic [3:0] rr);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.r = 1'b1;
        t.g = g; t.b = b; t.ev = ev; t.ed = ed; t.rr = rr;
        return t;
    endfunction

    vec_t tbl[22];

    // Reference model state for the random phase.
    int         m_owner;
    int         m_grant;
    int         m_ptr;
    int         m_beats;
    int         p_seq[NR];
    int         sb_seq[NR];
    logic [3:0] acc;

    function automatic int pick(input logic [3:0] m, input int s);
        for (int k = 0; k < NR; k++) if (m[(s + k) % NR]) return (s + k) % NR;
        return -1;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "timeout");
    end

    initial begin
        // Round robin 0,1,2,3,0 with 2-beat bursts, then MAX_BURST split of req1 around req2.
        tbl[0]  = mk(4'hF, 32'h40302010, 4'h0, 2'd0, 0, 0, 8'h00, 4'h0);
        tbl[1]  = mk(4'hF, 32'h40302010, 4'h0, 2'd0, 1, 1, 8'h10, 4'h1);
        tbl[2]  = mk(4'hF, 32'h40302011, 4'h1, 2'd0, 1, 1, 8'h11, 4'h1);
        tbl[3]  = mk(4'hF, 32'h40302012, 4'h0, 2'd1, 1, 1, 8'h20, 4'h2);
        tbl[4]  = mk(4'hF, 32'h40302112, 4'h2, 2'd1, 1, 1, 8'h21, 4'h2);
        tbl[5]  = mk(4'hF, 32'h40302212, 4'h0, 2'd2, 1, 1, 8'h30, 4'h4);
        tbl[6]  = mk(4'hF, 32'h40312212, 4'h4, 2'd2, 1, 1, 8'h31, 4'h4);
        tbl[7]  = mk(4'hF, 32'h40322212, 4'h0, 2'd3, 1, 1, 8'h40, 4'h8);
        tbl[8]  = mk(4'hF, 32'h41322212, 4'h8, 2'd3, 1, 1, 8'h41, 4'h8);
        tbl[9]  = mk(4'hF, 32'h42322212, 4'h0, 2'd0, 1, 1, 8'h12, 4'h1);
        tbl[10] = mk(4'h1, 32'h42322213, 4'h1, 2'd0, 1, 1, 8'h13, 4'h1);
        tbl[11] = mk(4'h0, 32'h00000000, 4'h0, 2'd0, 0, 0, 8'h00, 4'h0);
        tbl[12] = mk(4'h6, 32'h00504000, 4'h0, 2'd0, 0, 0, 8'h00, 4'h0);
        tbl[13] = mk(4'h6, 32'h00504000, 4'h0, 2'd1, 1, 1, 8'h40, 4'h2);
        tbl[14] = mk(4'h6, 32'h00504100, 4'h0, 2'd1, 1, 1, 8'h41, 4'h2);
        tbl[15] = mk(4'h6, 32'h00504200, 4'h0, 2'd1, 1, 1, 8'h42, 4'h2);
        tbl[16] = mk(4'h6, 32'h00504300, 4'h0, 2'd1, 1, 1, 8'h43, 4'h2);
        tbl[17] = mk(4'h6, 32'h00504400, 4'h0, 2'd2, 1, 1, 8'h50, 4'h4);
        tbl[18] = mk(4'h6, 32'h00514400, 4'h4, 2'd2, 1, 1, 8'h51, 4'h4);
        tbl[19] = mk(4'h2, 32'h00004400, 4'h0, 2'd1, 1, 1, 8'h44, 4'h2);
        tbl[20] = mk(4'h2, 32'h00004500, 4'h2, 2'd1, 1, 1, 8'h45, 4'h2);
        tbl[21] = mk(4'h0, 32'h00000000, 4'h0, 2'd1, 0, 0, 8'h00, 4'h0);

        // Reset state, with requests already pending.
        reset_n   = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'hFFFFFFFF;
        req_last  = 4'h0;
        enq_ready = 1'b1;
        #3;
        check_outs("reset", 2'd0, 0, 0, 8'h00, 4'h0);
        req_valid = 4'h0;
        req_data  = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            check_outs($sformatf("vec%0d", i), tbl[i].g, tbl[i].b, tbl[i].ev, tbl[i].ed, tbl[i].rr);
        end

        // Fifo full for 10 cycles mid-burst: everything held, nothing accepted.
        step(4'h1, 32'h60, 4'h0, 1'b1);
        check_outs("stall_idle", 2'd1, 0, 0, 8'h00, 4'h0);
        step(4'h1, 32'h60, 4'h0, 1'b1);
        check_outs("stall_b0", 2'd0, 1, 1, 8'h60, 4'h1);
        for (int i = 0; i < 10; i++) begin
            step(4'h1, 32'h61, 4'h0, 1'b0);
            check_outs($sformatf("stall_hold%0d", i), 2'd0, 1, 1, 8'h61, 4'h0);
        end
        step(4'h1, 32'h61, 4'h0, 1'b1);
        check_outs("stall_b1", 2'd0, 1, 1, 8'h61, 4'h1);
        step(4'h1, 32'h62, 4'h1, 1'b1);
        check_outs("stall_b2", 2'd0, 1, 1, 8'h62, 4'h1);
        step(4'h0, 32'h0, 4'h0, 1'b1);
        check_outs("stall_end", 2'd0, 0, 0, 8'h00, 4'h0);

        // Reset mid-burst of req2, with rr_ptr=1 beforehand; afterwards the scan starts at req0.
        step(4'h4, 32'h00800000, 4'h0, 1'b1);
        check_outs("rst_idle", 2'd0, 0, 0, 8'h00, 4'h0);
        step(4'h4, 32'h00800000, 4'h0, 1'b1);
        check_outs("rst_b0", 2'd2, 1, 1, 8'h80, 4'h4);
        step(4'h5, 32'h00810099, 4'h0, 1'b1);
        check_outs("rst_b1", 2'd2, 1, 1, 8'h81, 4'h4);
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("rst_async", 2'd0, 0, 0, 8'h00, 4'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step(4'h5, 32'h00810099, 4'h0, 1'b1);
        check_outs("rst_regrant", 2'd0, 1, 1, 8'h99, 4'h1);
        step(4'h0, 32'h00810099, 4'h0, 1'b1);
        check_outs("owner_gap", 2'd0, 1, 0, 8'h99, 4'h1);
        step(4'h1, 32'h0000009A, 4'h1, 1'b1);
        check_outs("owner_last", 2'd0, 1, 1, 8'h9A, 4'h1);

        // Lone requester: one idle bubble between its two bursts.
        step(4'h8, 32'h70000000, 4'h8, 1'b1);
        check_outs("lone_idle", 2'd0, 0, 0, 8'h00, 4'h0);
        step(4'h8, 32'h70000000, 4'h8, 1'b1);
        check_outs("lone_b0", 2'd3, 1, 1, 8'h70, 4'h8);
        step(4'h8, 32'h71000000, 4'h8, 1'b1);
        check_outs("lone_bubble", 2'd3, 0, 0, 8'h00, 4'h0);
        step(4'h8, 32'h71000000, 4'h8, 1'b1);
        check_outs("lone_b1", 2'd3, 1, 1, 8'h71, 4'h8);
        step(4'h0, 32'h0, 4'h0, 1'b1);
        check_outs("lone_end", 2'd3, 0, 0, 8'h00, 4'h0);

        // Random traffic against a burst-level model plus per-producer order scoreboard.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_owner = -1;
        m_grant = 0;
        m_ptr   = 0;
        m_beats = 0;
        acc     = '0;
        for (int i = 0; i < NR; i++) begin
            p_seq[i]  = 0;
            sb_seq[i] = 0;
        end
        for (int cyc = 0; cyc < 20000; cyc++) begin
            logic        e_ev;
            logic [7:0]  e_ed;
            logic [3:0]  e_rr;
            logic [3:0]  cand;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) p_seq[i]++;
                if (acc[i] || !req_valid[i]) req_valid[i] = ($urandom_range(0, 1) == 1);
                else if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
                req_data[i*DW +: DW] = 8'((i << 6) | (p_seq[i] & 63));
                req_last[i] = ($urandom_range(0, 2) == 0);
            end
            enq_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);

            e_ev = 1'b0;
            e_ed = '0;
            e_rr = '0;
            if (m_owner >= 0) begin
                e_ev = req_valid[m_owner];
                e_ed = req_data[m_owner*DW +: DW];
                e_rr[m_owner] = enq_ready;
            end
            chk($sformatf("rnd_outputs_cyc%0d", cyc),
                {grant_id, busy, enq_valid, enq_data, req_ready},
                {2'(m_grant), (m_owner >= 0), e_ev, e_ed, e_rr});
            acc = req_valid & e_rr;

            if (m_owner < 0) begin
                m_owner = pick(req_valid, m_ptr);
                if (m_owner >= 0) m_grant = m_owner;
            end else if (e_ev && enq_ready) begin
                chk($sformatf("rnd_order_p%0d", m_owner), 32'(enq_data),
                    32'((m_owner << 6) | (sb_seq[m_owner] & 63)));
                sb_seq[m_owner]++;
                m_beats++;
                if (req_last[m_owner] || m_beats == MB) begin
                    m_ptr   = (m_owner + 1) % NR;
                    m_beats = 0;
                    cand    = req_valid;
                    cand[m_owner] = 1'b0;
                    m_owner = pick(cand, m_ptr);
                    if (m_owner >= 0) m_grant = m_owner;
                end
            end
            if (n_total - n_pass > 20) break;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
